// File: rtl/bist_misr_checker.sv
// bist_misr_checker
// Multi-channel signature analyser (MISR) for the grayscale/Sobel BIST path.
// Each channel compacts its own pixel stream into a SIG_W-bit signature and
// counts the accepted samples. At frame end every post-update signature is
// compared with a host-supplied expected value.
//
// Ports:
//   clk, nreset_i      clock, asynchronous active-low reset
//   en_i               accumulate enable (IDLE->RUN, pause when low)
//   clear_i            synchronous clear, highest priority
//   rdy_i, data_i      per-channel sample strobe and packed samples
//   frame_done_i       end-of-frame strobe (RUN->DONE, triggers compare)
//   expected_i         packed expected signatures
//   sig_sel_i          readback channel select
//   signature_o        signature of selected channel (0 if out of range)
//   count_o            sample count of selected channel (0 if out of range)
//   busy_o, done_o     registered state flags (RUN, DONE)
//   pass_o             registered per-channel compare result
//   all_pass_o         done_o & all channels passing
module bist_misr_checker #(
  parameter int               NUM_CH = 2,
  parameter int               DATA_W = 8,
  parameter int               SIG_W  = 24,
  parameter logic [SIG_W-1:0] POLY   = 24'h80000D,
  parameter logic [SIG_W-1:0] SEED   = 24'h000000,
  parameter int               CNT_W  = 16,
  parameter int               SEL_W  = 1
) (
  input  logic                       clk,
  input  logic                       nreset_i,
  input  logic                       en_i,
  input  logic                       clear_i,
  input  logic [NUM_CH-1:0]          rdy_i,
  input  logic [NUM_CH*DATA_W-1:0]   data_i,
  input  logic                       frame_done_i,
  input  logic [NUM_CH*SIG_W-1:0]    expected_i,
  input  logic [SEL_W-1:0]           sig_sel_i,
  output logic [SIG_W-1:0]           signature_o,
  output logic [CNT_W-1:0]           count_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [NUM_CH-1:0]          pass_o,
  output logic                       all_pass_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [SIG_W-1:0]  sig_q [NUM_CH];
  logic [SIG_W-1:0]  sig_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [NUM_CH-1:0] pass_q, pass_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              accept_s;

  // One MISR shift: multiply by x modulo the polynomial, then fold in the sample.
  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] sig,
                                                 input logic [DATA_W-1:0] data);
    logic [SIG_W-1:0] fb;
    logic [SIG_W-1:0] ext;
    fb  = sig[SIG_W-1] ? POLY : {SIG_W{1'b0}};
    ext = {SIG_W{1'b0}};
    ext[DATA_W-1:0] = data;
    misr_step = {sig[SIG_W-2:0], 1'b0} ^ fb ^ ext;
  endfunction

  // Next-state, signature/count update and compare capture.
  always_comb begin
    state_d  = state_q;
    sig_d    = sig_q;
    cnt_d    = cnt_q;
    pass_d   = pass_q;
    accept_s = 1'b0;
    if (clear_i) begin
      state_d = ST_IDLE;
      pass_d  = {NUM_CH{1'b0}};
      for (int c = 0; c < NUM_CH; c++) begin
        sig_d[c] = SEED;
        cnt_d[c] = {CNT_W{1'b0}};
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = en_i ? ST_RUN : ST_IDLE;
        end
        ST_RUN: begin
          // A cycle that drops en_i without frame_done_i is already the pause,
          // so its samples are not taken; the frame_done_i cycle always counts.
          accept_s = en_i | frame_done_i;
          for (int c = 0; c < NUM_CH; c++) begin
            if (accept_s && rdy_i[c]) begin
              sig_d[c] = misr_step(sig_q[c], data_i[c*DATA_W +: DATA_W]);
              cnt_d[c] = (cnt_q[c] == CNT_MAX) ? CNT_MAX : (cnt_q[c] + CNT_ONE);
            end else begin
              sig_d[c] = sig_q[c];
              cnt_d[c] = cnt_q[c];
            end
          end
          if (frame_done_i) begin
            state_d = ST_DONE;
            // Compare against the post-update signatures of this same cycle.
            for (int c = 0; c < NUM_CH; c++) begin
              pass_d[c] = (sig_d[c] == expected_i[c*SIG_W +: SIG_W]);
            end
          end else if (!en_i) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: begin
          state_d = en_i ? ST_DONE : ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State, signature, count and flag registers.
  always_ff @(posedge clk or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q <= ST_IDLE;
      pass_q  <= {NUM_CH{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        sig_q[c] <= SEED;
        cnt_q[c] <= {CNT_W{1'b0}};
      end
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      for (int c = 0; c < NUM_CH; c++) begin
        sig_q[c] <= sig_d[c];
        cnt_q[c] <= cnt_d[c];
      end
    end
  end

  // Readback mux; an out-of-range select matches no channel and reads 0.
  always_comb begin
    signature_o = {SIG_W{1'b0}};
    count_o     = {CNT_W{1'b0}};
    for (int c = 0; c < NUM_CH; c++) begin
      signature_o = signature_o | ((int'(sig_sel_i) == c) ? sig_q[c] : {SIG_W{1'b0}});
      count_o     = count_o     | ((int'(sig_sel_i) == c) ? cnt_q[c] : {CNT_W{1'b0}});
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign pass_o     = pass_q;
  assign all_pass_o = done_q & (&pass_q);

endmodule

// File: tb/tb_bist_misr_checker.sv
module tb_bist_misr_checker;

  localparam logic [23:0] POLY = 24'h80000D;

  logic        clk = 1'b0;
  logic        nreset_i;
  logic        en_i, clear_i, frame_done_i;
  logic [1:0]  rdy_i;
  logic [15:0] data_i;
  logic [47:0] expected_i;
  logic [0:0]  sig_sel_i;

  logic [23:0] sig_v [3];
  logic [15:0] cnt_v [2];
  logic [1:0]  cnt_s2;
  logic [2:0]  busy_v, done_v, allp_v;
  logic [1:0]  pass_v [3];

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // u0: default parameters, u1: non-zero seed, u2: 2-bit counters.
  bist_misr_checker u0 (
    .clk(clk), .nreset_i(nreset_i), .en_i(en_i), .clear_i(clear_i), .rdy_i(rdy_i),
    .data_i(data_i), .frame_done_i(frame_done_i), .expected_i(expected_i),
    .sig_sel_i(sig_sel_i), .signature_o(sig_v[0]), .count_o(cnt_v[0]),
    .busy_o(busy_v[0]), .done_o(done_v[0]), .pass_o(pass_v[0]), .all_pass_o(allp_v[0]));

  bist_misr_checker #(.SEED(24'h800000)) u1 (
    .clk(clk), .nreset_i(nreset_i), .en_i(en_i), .clear_i(clear_i), .rdy_i(rdy_i),
    .data_i(data_i), .frame_done_i(frame_done_i), .expected_i(expected_i),
    .sig_sel_i(sig_sel_i), .signature_o(sig_v[1]), .count_o(cnt_v[1]),
    .busy_o(busy_v[1]), .done_o(done_v[1]), .pass_o(pass_v[1]), .all_pass_o(allp_v[1]));

  bist_misr_checker #(.CNT_W(2)) u2 (
    .clk(clk), .nreset_i(nreset_i), .en_i(en_i), .clear_i(clear_i), .rdy_i(rdy_i),
    .data_i(data_i), .frame_done_i(frame_done_i), .expected_i(expected_i),
    .sig_sel_i(sig_sel_i), .signature_o(sig_v[2]), .count_o(cnt_s2),
    .busy_o(busy_v[2]), .done_o(done_v[2]), .pass_o(pass_v[2]), .all_pass_o(allp_v[2]));

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 running, 2 finished
  int          m_mode;
  logic [23:0] m_sig  [3][2];
  int          m_cnt  [3][2];
  logic [1:0]  m_pass [3];
  logic [23:0] seeds  [3] = '{24'h000000, 24'h800000, 24'h000000};
  int          lims   [3] = '{65535, 65535, 3};

  // Signature as a GF(2) polynomial: times x, reduced mod x^24 + POLY, plus sample.
  function automatic logic [23:0] mstep(input logic [23:0] s, input logic [7:0] d);
    logic [24:0] t;
    t = {s, 1'b0};
    if (t[24]) t = t ^ {1'b1, POLY};
    return t[23:0] ^ {16'h0, d};
  endfunction

  task automatic model_reset();
    m_mode = 0;
    for (int i = 0; i < 3; i++) begin
      m_pass[i] = 2'b00;
      for (int c = 0; c < 2; c++) begin
        m_sig[i][c] = seeds[i];
        m_cnt[i][c] = 0;
      end
    end
  endtask

  task automatic model_edge();
    if (!nreset_i || clear_i) begin
      model_reset();
    end else if (m_mode == 0) begin
      if (en_i) m_mode = 1;
    end else if (m_mode == 1) begin
      for (int i = 0; i < 3; i++) begin
        for (int c = 0; c < 2; c++) begin
          if ((en_i || frame_done_i) && rdy_i[c]) begin
            m_sig[i][c] = mstep(m_sig[i][c], data_i[c*8 +: 8]);
            if (m_cnt[i][c] < lims[i]) m_cnt[i][c]++;
          end
          if (frame_done_i) m_pass[i][c] = (m_sig[i][c] == expected_i[c*24 +: 24]);
        end
      end
      if (frame_done_i) m_mode = 2;
      else if (!en_i) m_mode = 0;
    end else begin
      if (!en_i) m_mode = 0;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [15:0] c_act;
    for (int i = 0; i < 3; i++) begin
      c_act = (i == 2) ? {14'h0, cnt_s2} : cnt_v[i];
      chk($sformatf("%s u%0d sig", tag, i), sig_v[i], m_sig[i][sig_sel_i]);
      chk($sformatf("%s u%0d cnt", tag, i), c_act, m_cnt[i][sig_sel_i]);
      chk($sformatf("%s u%0d busy", tag, i), busy_v[i], m_mode == 1);
      chk($sformatf("%s u%0d done", tag, i), done_v[i], m_mode == 2);
      chk($sformatf("%s u%0d pass", tag, i), pass_v[i], m_pass[i]);
      chk($sformatf("%s u%0d allp", tag, i), allp_v[i], (m_mode == 2) && (m_pass[i] == 2'b11));
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic en, clr, input logic [1:0] rdy,
                       input logic [7:0] d0, d1, input logic fd,
                       input logic [23:0] e0, e1, input logic sel);
    en_i = en; clear_i = clr; rdy_i = rdy; data_i = {d1, d0};
    frame_done_i = fd; expected_i = {e1, e0}; sig_sel_i = sel;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic en, clr; logic [1:0] rdy; logic [7:0] d0, d1; logic fd;
    logic [23:0] e0, e1; logic sel;
    logic [23:0] xsig; logic [15:0] xcnt; logic xbusy, xdone; logic [1:0] xpass; logic xall;
  } vec_t;

  function automatic vec_t mk(input logic en, clr, input logic [1:0] rdy,
                              input logic [7:0] d0, d1, input logic fd,
                              input logic [23:0] e0, e1, input logic sel,
                              input logic [23:0] xs, input logic [15:0] xc,
                              input logic xb, xd, input logic [1:0] xp, input logic xa);
    vec_t v;
    v.en = en; v.clr = clr; v.rdy = rdy; v.d0 = d0; v.d1 = d1; v.fd = fd;
    v.e0 = e0; v.e1 = e1; v.sel = sel; v.xsig = xs; v.xcnt = xc;
    v.xbusy = xb; v.xdone = xd; v.xpass = xp; v.xall = xa;
    return v;
  endfunction

  vec_t tbl [19];

  initial begin
    //               en   clr  rdy    d0     d1     fd   e0          e1          sel  sig         cnt     bsy  dn   pass   all
    tbl[0]  = mk(1'b1,1'b0,2'b00,8'h00,8'h00,1'b0,24'h0,     24'h0,     1'b0,24'h000000,16'd0,1'b1,1'b0,2'b00,1'b0);
    tbl[1]  = mk(1'b1,1'b0,2'b01,8'hA5,8'h00,1'b0,24'h0,     24'h0,     1'b0,24'h0000A5,16'd1,1'b1,1'b0,2'b00,1'b0);
    tbl[2]  = mk(1'b1,1'b0,2'b01,8'h01,8'h00,1'b1,24'h00014B,24'h000001,1'b0,24'h00014B,16'd2,1'b0,1'b1,2'b01,1'b0);
    tbl[3]  = mk(1'b1,1'b0,2'b11,8'hFF,8'hFF,1'b1,24'h0,     24'h0,     1'b0,24'h00014B,16'd2,1'b0,1'b1,2'b01,1'b0);
    tbl[4]  = mk(1'b1,1'b0,2'b00,8'h00,8'h00,1'b0,24'h0,     24'h0,     1'b1,24'h000000,16'd0,1'b0,1'b1,2'b01,1'b0);
    tbl[5]  = mk(1'b0,1'b0,2'b00,8'h00,8'h00,1'b0,24'h0,     24'h0,     1'b0,24'h00014B,16'd2,1'b0,1'b0,2'b01,1'b0);
    tbl[6]  = mk(1'b0,1'b1,2'b00,8'h00,8'h00,1'b0,24'h0,     24'h0,     1'b0,24'h000000,16'd0,1'b0,1'b0,2'b00,1'b0);
    tbl[7]  = mk(1'b1,1'b0,2'b00,8'h00,8'h00,1'b0,24'h0,     24'h0,     1'b0,24'h000000,16'd0,1'b1,1'b0,2'b00,1'b0);
    tbl[8]  = mk(1'b1,1'b0,2'b01,8'hA5,8'h00,1'b0,24'h0,     24'h0,     1'b0,24'h0000A5,16'd1,1'b1,1'b0,2'b00,1'b0);
    tbl[9]  = mk(1'b0,1'b0,2'b01,8'h33,8'h00,1'b0,24'h0,     24'h0,     1'b0,24'h0000A5,16'd1,1'b0,1'b0,2'b00,1'b0);
    tbl[10] = mk(1'b0,1'b0,2'b00,8'h00,8'h00,1'b1,24'h0,     24'h0,     1'b0,24'h0000A5,16'd1,1'b0,1'b0,2'b00,1'b0);
    tbl[11] = mk(1'b0,1'b0,2'b01,8'h77,8'h00,1'b0,24'h0,     24'h0,     1'b0,24'h0000A5,16'd1,1'b0,1'b0,2'b00,1'b0);
    tbl[12] = mk(1'b1,1'b0,2'b00,8'h00,8'h00,1'b0,24'h0,     24'h0,     1'b0,24'h0000A5,16'd1,1'b1,1'b0,2'b00,1'b0);
    tbl[13] = mk(1'b1,1'b0,2'b01,8'h01,8'h00,1'b0,24'h0,     24'h0,     1'b0,24'h00014B,16'd2,1'b1,1'b0,2'b00,1'b0);
    tbl[14] = mk(1'b1,1'b1,2'b11,8'h12,8'h34,1'b1,24'h0,     24'h0,     1'b0,24'h000000,16'd0,1'b0,1'b0,2'b00,1'b0);
    tbl[15] = mk(1'b1,1'b0,2'b00,8'h00,8'h00,1'b0,24'h0,     24'h0,     1'b0,24'h000000,16'd0,1'b1,1'b0,2'b00,1'b0);
    tbl[16] = mk(1'b1,1'b0,2'b11,8'hA5,8'h3C,1'b1,24'h0000A5,24'h00003C,1'b0,24'h0000A5,16'd1,1'b0,1'b1,2'b11,1'b1);
    tbl[17] = mk(1'b0,1'b0,2'b00,8'h00,8'h00,1'b0,24'h0,     24'h0,     1'b1,24'h00003C,16'd1,1'b0,1'b0,2'b11,1'b0);
    tbl[18] = mk(1'b0,1'b1,2'b00,8'h00,8'h00,1'b0,24'h0,     24'h0,     1'b0,24'h000000,16'd0,1'b0,1'b0,2'b00,1'b0);

    // Reset state
    nreset_i = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 24'h0, 24'h0, 1'b0);
    model_reset();
    #12;
    chk("rst sig", sig_v[0], 24'h000000);
    chk("rst seed sig", sig_v[1], 24'h800000);
    chk("rst cnt", cnt_v[0], 16'd0);
    chk("rst flags", {busy_v[0], done_v[0], pass_v[0], allp_v[0]}, 5'b00000);
    check_all("rst");
    @(posedge clk); #1;
    nreset_i = 1'b1;

    // Directed table on u0 (the model also cross-checks every instance)
    for (int k = 0; k < 19; k++) begin
      drive(tbl[k].en, tbl[k].clr, tbl[k].rdy, tbl[k].d0, tbl[k].d1, tbl[k].fd,
            tbl[k].e0, tbl[k].e1, tbl[k].sel);
      tick($sformatf("tbl%0d", k));
      chk($sformatf("tbl%0d sig", k), sig_v[0], tbl[k].xsig);
      chk($sformatf("tbl%0d cnt", k), cnt_v[0], tbl[k].xcnt);
      chk($sformatf("tbl%0d busy", k), busy_v[0], tbl[k].xbusy);
      chk($sformatf("tbl%0d done", k), done_v[0], tbl[k].xdone);
      chk($sformatf("tbl%0d pass", k), pass_v[0], tbl[k].xpass);
      chk($sformatf("tbl%0d allp", k), allp_v[0], tbl[k].xall);
    end

    // Feedback from a seed with the top bit set
    drive(1'b1, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 24'h0, 24'h0, 1'b0);
    tick("fb0");
    drive(1'b1, 1'b0, 2'b01, 8'h00, 8'h00, 1'b0, 24'h0, 24'h0, 1'b0);
    tick("fb1");
    chk("feedback sig", sig_v[1], 24'h80000D);

    // Counter saturation on the 2-bit instance after five samples
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, 2'b01, 8'($urandom), 8'h00, 1'b0, 24'h0, 24'h0, 1'b0);
      tick("sat");
    end
    chk("sat cnt2", cnt_s2, 2'd3);
    chk("sat cnt16", cnt_v[0], 16'd5);

    // Channel 1 readback on the saturating instance
    drive(1'b1, 1'b0, 2'b11, 8'h00, 8'h5A, 1'b0, 24'h0, 24'h0, 1'b1);
    tick("sel1");
    chk("sel1 sig", sig_v[2], 24'h00005A);
    chk("sel1 cnt", cnt_s2, 2'd1);

    // Asynchronous reset in the middle of RUN takes effect before any edge
    nreset_i = 1'b0;
    #2;
    model_reset();
    chk("arst busy", busy_v[0], 1'b0);
    chk("arst sig", sig_v[0], 24'h000000);
    chk("arst cnt", cnt_v[0], 16'd0);
    check_all("arst");
    @(posedge clk); #1;
    nreset_i = 1'b1;

    // Randomised traffic against the model
    for (int k = 0; k < 3000; k++) begin
      logic [1:0]  r;
      logic [7:0]  d0, d1;
      logic [23:0] e [2];
      r  = 2'($urandom);
      d0 = 8'($urandom);
      d1 = 8'($urandom);
      for (int c = 0; c < 2; c++) begin
        if ($urandom_range(1, 0) == 1)
          e[c] = r[c] ? mstep(m_sig[0][c], (c == 0) ? d0 : d1) : m_sig[0][c];
        else
          e[c] = 24'($urandom);
      end
      drive(($urandom_range(7, 0) != 0), ($urandom_range(63, 0) == 0), r, d0, d1,
            ($urandom_range(15, 0) == 0), e[0], e[1], 1'($urandom));
      tick("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bist_misr_checker.md
Name: bist_misr_checker

Overview:
Multi-channel parametrised signature analyser (MISR) for the grayscale/Sobel BIST path. It compacts up to NUM_CH independent pixel streams into per-channel signatures over a frame. At frame end it compares each signature against a host-supplied expected value and reports per-channel and aggregate pass/fail. It sits between the image pipeline/LFSR outputs and the SPI readback mux, and supersedes the single-channel, compare-less analyser.

Parameters:
NUM_CH, 2, number of independent input channels (1..8)
DATA_W, 8, pixel width per channel; must satisfy DATA_W <= SIG_W
SIG_W, 24, signature register width
POLY, 24'h80000D, feedback polynomial XOR mask, SIG_W bits, implicit x^SIG_W term
SEED, 24'h000000, signature value after clear/reset
CNT_W, 16, per-channel sample counter width
SEL_W, 1, width of sig_sel_i; must satisfy SEL_W = max(1, clog2(NUM_CH))

Ports:
clk  in  1  clock
nreset_i  in  1  reset, asynchronous, active-low
en_i  in  1  accumulate enable (already synchronised)
clear_i  in  1  synchronous clear, highest priority
rdy_i  in  NUM_CH  per-channel sample strobe
data_i  in  NUM_CH*DATA_W  packed samples; channel c occupies [c*DATA_W +: DATA_W]
frame_done_i  in  1  end-of-frame strobe
expected_i  in  NUM_CH*SIG_W  packed expected signatures; must be stable when frame_done_i is high
sig_sel_i  in  SEL_W  readback channel select
signature_o  out  SIG_W  signature of the selected channel
count_o  out  CNT_W  sample count of the selected channel
busy_o  out  1  high in RUN
done_o  out  1  high in DONE
pass_o  out  NUM_CH  per-channel compare result
all_pass_o  out  1  done_o & (&pass_o)

Behaviour:
- Reset (async): state IDLE, all signatures = SEED, counts = 0, pass_o = 0, done_o = 0, busy_o = 0. signature_o and count_o therefore read SEED and 0.
- MISR update for channel c when accepted: sig <= {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ zero-extended data_c.
- Count update on the same accepted sample: count <= count+1, saturating at 2^CNT_W-1 with no wrap.
- Channels update independently. Simultaneous rdy_i on several channels are all accepted in the same cycle.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN when en_i=1. Samples are not accepted in IDLE.
  - RUN: accept samples on every cycle where rdy_i[c]=1.
  - RUN -> DONE on frame_done_i=1. Samples arriving in that same cycle are included. The compare uses the post-update signatures.
  - pass_o[c] = (next_sig_c == expected_c), registered on the same edge that enters DONE. done_o and pass_o are therefore valid exactly 1 cycle after the frame_done_i cycle.
  - RUN -> IDLE when en_i=0 and frame_done_i=0. Signatures and counts are held. Re-asserting en_i resumes accumulation without clearing (pause/resume).
  - DONE: signatures frozen, rdy_i and frame_done_i ignored, pass_o held. DONE -> IDLE on en_i=0 (values held). Staying enabled keeps the block in DONE.
  - frame_done_i in IDLE is ignored.
- clear_i=1 (any state): next cycle state IDLE, signatures = SEED, counts = 0, pass_o = 0, done_o = 0. clear_i wins over en_i, rdy_i and frame_done_i in the same cycle.
- Readback: signature_o and count_o are combinational muxes on sig_sel_i over the registered values. If sig_sel_i >= NUM_CH, both read 0.
- all_pass_o is 0 whenever done_o = 0.
- Outputs busy_o, done_o and pass_o are registered.

Test Plan:
- Reset, then NUM_CH=2 with en_i=1 and ch0 samples 0xA5 then 0x01 -> sig0 = 0x0000A5, then 0x00014B; count_o = 2; sig1 remains 0x000000.
- Feedback check: SEED=0x800000, ch0 sample 0x00 in RUN -> sig0 = 0x80000D.
- frame_done_i on the same cycle as the ch0 sample 0x01 (after 0xA5), with expected0 = 0x00014B and expected1 = 0x000001 -> one cycle later done_o=1, pass_o=2'b01, all_pass_o=0.
- Pause/resume: 0xA5, then en_i=0 for 3 cycles with rdy_i toggling, then en_i=1 and 0x01 -> sig0 = 0x00014B (paused samples ignored).
- clear_i asserted together with frame_done_i and rdy_i -> next cycle state IDLE, sigs = SEED, done_o=0, pass_o=0.
- CNT_W=2 with 5 samples -> count_o saturates at 3. sig_sel_i=1 reads ch1. Async reset asserted mid-RUN -> all outputs return to reset values immediately.
